// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//
// Pipelined N-bit adder/subtractor with optional saturation and a
// valid/ready handshake on both sides. The carry chain is cut into STAGES
// segments of W = N/STAGES bits. Stage k adds segment k using the carry that
// stage k-1 registered. Stage 0 uses the transformed carry-in.
//
// Handshake (strict valid/ready):
//   A beat transfers on a rising clk edge where valid & ready are both 1.
//   The producer holds the beat stable until it transfers. in_ready is
//   ~out_valid | out_ready. When in_ready is 0 the whole pipeline freezes,
//   so out_valid and every result output hold until out_ready is 1.
//   An empty slot travels through the pipe as a cleared valid bit.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  operand beat handshake
//   a, b, cin          operands and carry/borrow in
//   sub_en             1: a - b - cin, 0: a + b + cin
//   signed_en          two's-complement flags and saturation
//   sat_en             clamp the result on overflow
//   out_valid/out_ready result beat handshake
//   sum                result (raw or saturated)
//   cout               raw carry out of bit N-1
//   negative_flag      signed_en & sum[N-1] (after saturation)
//   overflow_flag      overflow of the raw result
//   zero_flag          sum == 0 (after saturation)
// ---------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int N      = 64,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub_en,
  input  logic         signed_en,
  input  logic         sat_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         negative_flag,
  output logic         overflow_flag,
  output logic         zero_flag
);

  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;

  // Per-stage pipeline registers. Each stage holds the operands, which form
  // the skew path for the segments still to be added, the partial result with
  // the finished lower segments, and the carry out of its own segment.
  logic [STAGES-1:0] valid_q;
  logic [N-1:0]      a_q     [STAGES];
  logic [N-1:0]      b_q     [STAGES];
  logic [N-1:0]      res_q   [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] sub_q;
  logic [STAGES-1:0] sgn_q;
  logic [STAGES-1:0] sat_q;

  // Result registers. These form the output side of the last stage.
  logic [N-1:0] sum_q;
  logic         cout_q;
  logic         neg_q;
  logic         ovf_q;
  logic         zero_q;

  // Inputs to each stage. Stage 0 reads the ports. Stage k reads stage k-1.
  logic [STAGES-1:0] src_valid;
  logic [N-1:0]      src_a   [STAGES];
  logic [N-1:0]      src_b   [STAGES];
  logic [N-1:0]      src_res [STAGES];
  logic [STAGES-1:0] src_carry;
  logic [STAGES-1:0] src_sub;
  logic [STAGES-1:0] src_sgn;
  logic [STAGES-1:0] src_sat;

  // Next-state values from each stage's segment adder.
  logic [N-1:0]      res_d   [STAGES];
  logic [STAGES-1:0] carry_d;

  // Final-stage flag and saturation logic.
  logic [N-1:0] raw;
  logic         raw_carry;
  logic         a_msb;
  logic         b_msb;
  logic         ovf_d;
  logic [N-1:0] sat_val;
  logic [N-1:0] sum_d;
  logic         neg_d;
  logic         zero_d;

  logic advance;

  // Any free slot at the output lets the whole pipe move forward by one.
  assign advance  = ~valid_q[L] | out_ready;
  assign in_ready = advance;

  // Stage source selection.
  always_comb begin
    src_valid    = '0;
    src_carry    = '0;
    src_sub      = '0;
    src_sgn      = '0;
    src_sat      = '0;
    src_valid[0] = in_valid;
    src_a[0]     = a;
    // Subtraction is a + ~b + ~cin. The borrow-in becomes an inverted carry.
    src_b[0]     = sub_en ? ~b : b;
    src_carry[0] = sub_en ^ cin;
    src_res[0]   = '0;
    src_sub[0]   = sub_en;
    src_sgn[0]   = signed_en;
    src_sat[0]   = sat_en;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_res[k]   = res_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_sub[k]   = sub_q[k-1];
      src_sgn[k]   = sgn_q[k-1];
      src_sat[k]   = sat_q[k-1];
    end
  end

  // Segment adders. Stage k fills in bits [k*W +: W] and keeps lower ones.
  always_comb begin
    logic [W:0] seg;
    seg     = '0;
    carry_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg = {1'b0, src_a[k][k*W +: W]}
          + {1'b0, src_b[k][k*W +: W]}
          + {{W{1'b0}}, src_carry[k]};
      res_d[k]            = src_res[k];
      res_d[k][k*W +: W]  = seg[W-1:0];
      carry_d[k]          = seg[W];
    end
  end

  // Flags and saturation on the fully assembled raw result.
  always_comb begin
    raw       = res_d[L];
    raw_carry = carry_d[L];
    a_msb     = src_a[L][N-1];
    b_msb     = src_b[L][N-1];
    ovf_d     = 1'b0;
    sat_val   = '0;
    if (src_sgn[L]) begin
      // Signed overflow: the operand signs match and the result sign differs.
      ovf_d   = (a_msb == b_msb) & (raw[N-1] != a_msb);
      sat_val = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else if (src_sub[L]) begin
      // A missing carry out of a + ~b + 1 is a borrow.
      ovf_d   = ~raw_carry;
      sat_val = '0;
    end else begin
      ovf_d   = raw_carry;
      sat_val = '1;
    end
    sum_d  = (src_sat[L] & ovf_d) ? sat_val : raw;
    neg_d  = src_sgn[L] & sum_d[N-1];
    zero_d = (sum_d == '0);
  end

  // Register stages. The data registers load on every advance, even for an
  // empty slot. The valid bit alone tells a real beat from an empty one.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sub_q   <= '0;
      sgn_q   <= '0;
      sat_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
      sum_q  <= '0;
      cout_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      valid_q <= src_valid;
      carry_q <= carry_d;
      sub_q   <= src_sub;
      sgn_q   <= src_sgn;
      sat_q   <= src_sat;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= src_a[k];
        b_q[k]   <= src_b[k];
        res_q[k] <= res_d[k];
      end
      sum_q  <= sum_d;
      cout_q <= raw_carry;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid     = valid_q[L];
  assign sum           = sum_q;
  assign cout          = cout_q;
  assign negative_flag = neg_q;
  assign overflow_flag = ovf_q;
  assign zero_flag     = zero_q;

endmodule
